// File: rtl/triumph_if_stage_pkg.sv
// triumph_if_stage_pkg
//   Shared constants and types for the instruction-fetch stage:
//   - IF_NOP            : canonical NOP (addi x0,x0,0) shown while nothing was fetched
//   - BOOT_ADDR_DEFAULT : default first fetch address after reset
//   - if_state_e        : fetch FSM state encoding (exposed on the debug port)
//   - word_align        : clears address bits [1:0]
package triumph_if_stage_pkg;

  localparam logic [31:0] IF_NOP            = 32'h0000_0013;
  localparam logic [31:0] BOOT_ADDR_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    IF_S_REQ   = 2'd0,  // free to request, nothing outstanding
    IF_S_WAIT  = 2'd1,  // granted, response will be loaded
    IF_S_FLUSH = 2'd2   // granted, response will be dropped
  } if_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/triumph_if_stage.sv
// triumph_if_stage
//   Instruction-fetch stage with the IF/ID pipeline register. Generates the PC,
//   fetches over a req/gnt/rvalid port with at most one transaction in flight,
//   and holds the fetched word for the ID stage.
//
//   Handshakes:
//     Memory side : a request transfers on a cycle with instr_req_o && instr_gnt_i;
//                   once raised, instr_req_o and instr_addr_o stay stable until
//                   granted unless a redirect arrives. instr_rvalid_i returns the
//                   single outstanding response one or more cycles later.
//     ID side     : the word transfers on a cycle with instr_valid_o && id_ready_i;
//                   instr_o/pc_o are stable while instr_valid_o is high and not taken.
//
//   Ports:
//     clk_i, rst_i                  clock, synchronous active-high reset
//     instr_req_o / instr_addr_o    fetch request and word-aligned address
//     instr_gnt_i                   memory accepts the request
//     instr_rvalid_i/instr_rdata_i  read response
//     redirect_i / redirect_pc_i    PC redirect from EX (target low bits masked)
//     id_ready_i                    ID consumes the output register
//     instr_valid_o/instr_o/pc_o    output register toward ID
//     opcode_o/funct3_o/funct7_o    decode fields sliced from instr_o
//     dbg_state_o                   current fetch FSM state (if_state_e encoding)
module triumph_if_stage
  import triumph_if_stage_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR = BOOT_ADDR_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        id_ready_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [6:0]  opcode_o,
  output logic [2:0]  funct3_o,
  output logic [6:0]  funct7_o,
  output logic [1:0]  dbg_state_o
);

  if_state_e   r_state;
  logic [31:0] r_pc;
  logic [31:0] r_fetch_pc;
  logic        r_valid;
  logic [31:0] r_instr;
  logic [31:0] r_pc_out;

  logic        w_req;
  logic        w_load;
  logic [31:0] w_redirect_pc;

  // A request is only issued when the single output slot is free or is being
  // drained this cycle, so the response always has somewhere to land.
  assign w_req         = (r_state == IF_S_REQ) && !redirect_i && (!r_valid || id_ready_i);
  assign w_load        = (r_state == IF_S_WAIT) && instr_rvalid_i && !redirect_i;
  assign w_redirect_pc = word_align(redirect_pc_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= IF_S_REQ;
      r_pc       <= word_align(BOOT_ADDR);
      r_fetch_pc <= word_align(BOOT_ADDR);
      r_valid    <= 1'b0;
      r_instr    <= IF_NOP;
      r_pc_out   <= 32'h0000_0000;
    end else begin
      // Output register: redirect beats load, load beats consume.
      if (redirect_i) begin
        r_valid <= 1'b0;
      end else if (w_load) begin
        r_valid  <= 1'b1;
        r_instr  <= instr_rdata_i;
        r_pc_out <= r_fetch_pc;
      end else if (id_ready_i && r_valid) begin
        r_valid <= 1'b0;
      end

      case (r_state)
        IF_S_REQ: begin
          if (redirect_i) begin
            r_pc <= w_redirect_pc;
          end else if (w_req && instr_gnt_i) begin
            r_fetch_pc <= r_pc;
            r_pc       <= r_pc + 32'd4;
            r_state    <= IF_S_WAIT;
          end
        end
        IF_S_WAIT: begin
          if (redirect_i) begin
            r_pc <= w_redirect_pc;
            // Response already here: drop it now; otherwise drop it when it comes.
            r_state <= instr_rvalid_i ? IF_S_REQ : IF_S_FLUSH;
          end else if (instr_rvalid_i) begin
            r_state <= IF_S_REQ;
          end
        end
        IF_S_FLUSH: begin
          if (redirect_i) begin
            r_pc <= w_redirect_pc;
          end
          if (instr_rvalid_i) begin
            r_state <= IF_S_REQ;
          end
        end
        default: begin
          r_state <= IF_S_REQ;
        end
      endcase
    end
  end

  assign instr_req_o   = w_req;
  assign instr_addr_o  = r_pc;
  assign instr_valid_o = r_valid;
  assign instr_o       = r_instr;
  assign pc_o          = r_pc_out;
  assign opcode_o      = r_instr[6:0];
  assign funct3_o      = r_instr[14:12];
  assign funct7_o      = r_instr[31:25];
  assign dbg_state_o   = r_state;

endmodule

// File: tb/tb_triumph_if_stage.sv
module tb_triumph_if_stage;

  localparam logic [1:0] ST_REQ   = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;

  triumph_if_stage #(.BOOT_ADDR(32'h0000_0000)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .instr_req_o    (req),
    .instr_addr_o   (addr),
    .instr_gnt_i    (gnt),
    .instr_rvalid_i (rvalid),
    .instr_rdata_i  (rdata),
    .redirect_i     (redirect),
    .redirect_pc_i  (redirect_pc),
    .id_ready_i     (id_ready),
    .instr_valid_o  (valid),
    .instr_o        (instr),
    .pc_o           (pc),
    .opcode_o       (opcode),
    .funct3_o       (funct3),
    .funct7_o       (funct7),
    .dbg_state_o    (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one cycle and settle just past the rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    cyc();
    cyc();
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid); end
    checks++; if (instr !== NOP) begin errors++; $display("FAIL reset_instr got %h exp %h", instr, NOP); end
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp 0", pc); end
    checks++; if (state !== ST_REQ) begin errors++; $display("FAIL reset_state got %0d exp %0d", state, ST_REQ); end
    checks++; if (opcode !== 7'h13) begin errors++; $display("FAIL reset_opcode got %h exp 13", opcode); end
    checks++; if (addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", addr); end
  endtask

  task automatic test_first_fetch();
    rst = 1'b0; gnt = 1'b1; #1;
    checks++; if (req !== 1'b1) begin errors++; $display("FAIL ff_req got %b exp 1", req); end
    checks++; if (addr !== 32'h0) begin errors++; $display("FAIL ff_addr got %h exp 0", addr); end
    cyc();
    checks++; if (state !== ST_WAIT) begin errors++; $display("FAIL ff_state_wait got %0d exp %0d", state, ST_WAIT); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL ff_valid_c1 got %b exp 0", valid); end
    gnt = 1'b0; rvalid = 1'b1; rdata = 32'h0010_0093; #1;
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL ff_req_wait got %b exp 0", req); end
    cyc();
    rvalid = 1'b0; rdata = 32'h0; #1;
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL ff_valid_c2 got %b exp 1", valid); end
    checks++; if (instr !== 32'h0010_0093) begin errors++; $display("FAIL ff_instr got %h exp 00100093", instr); end
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL ff_pc got %h exp 0", pc); end
    checks++; if (opcode !== 7'h13) begin errors++; $display("FAIL ff_opcode got %h exp 13", opcode); end
    checks++; if (funct3 !== 3'h0) begin errors++; $display("FAIL ff_funct3 got %h exp 0", funct3); end
    checks++; if (addr !== 32'h4) begin errors++; $display("FAIL ff_next_addr got %h exp 4", addr); end
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL ff_req_full got %b exp 0", req); end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 5; i++) begin
      cyc();
      checks++; if (req !== 1'b0) begin errors++; $display("FAIL stall_req[%0d] got %b exp 0", i, req); end
      checks++; if (valid !== 1'b1 || instr !== 32'h0010_0093 || pc !== 32'h0) begin
        errors++; $display("FAIL stall_hold[%0d] got v=%b i=%h pc=%h exp v=1 i=00100093 pc=0", i, valid, instr, pc);
      end
    end
    id_ready = 1'b1; #1;
    checks++; if (req !== 1'b1 || addr !== 32'h4) begin errors++; $display("FAIL stall_release got req=%b addr=%h exp req=1 addr=4", req, addr); end
    cyc();
    id_ready = 1'b0; #1;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL stall_consume got %b exp 0", valid); end
    checks++; if (state !== ST_REQ) begin errors++; $display("FAIL stall_state got %0d exp %0d", state, ST_REQ); end
  endtask

  task automatic test_gnt_delay();
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (req !== 1'b1 || addr !== 32'h4) begin errors++; $display("FAIL gd_hold[%0d] got req=%b addr=%h exp req=1 addr=4", i, req, addr); end
      cyc();
    end
    gnt = 1'b1; #1;
    checks++; if (req !== 1'b1 || addr !== 32'h4) begin errors++; $display("FAIL gd_gnt got req=%b addr=%h exp req=1 addr=4", req, addr); end
    cyc();
    gnt = 1'b0; #1;
    checks++; if (state !== ST_WAIT || addr !== 32'h8) begin errors++; $display("FAIL gd_wait got st=%0d addr=%h exp st=1 addr=8", state, addr); end
    rvalid = 1'b1; rdata = 32'h4020_81B3;
    cyc();
    rvalid = 1'b0; #1;
    checks++; if (valid !== 1'b1 || pc !== 32'h4) begin errors++; $display("FAIL gd_load got v=%b pc=%h exp v=1 pc=4", valid, pc); end
    checks++; if (opcode !== 7'h33 || funct3 !== 3'h0 || funct7 !== 7'h20) begin
      errors++; $display("FAIL gd_fields got op=%h f3=%h f7=%h exp op=33 f3=0 f7=20", opcode, funct3, funct7);
    end
  endtask

  task automatic test_redirect_wait();
    id_ready = 1'b1; gnt = 1'b1; #1;
    checks++; if (req !== 1'b1 || addr !== 32'h8) begin errors++; $display("FAIL rw_req got req=%b addr=%h exp req=1 addr=8", req, addr); end
    cyc();
    gnt = 1'b0; id_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0103; #1;
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL rw_req_wait got %b exp 0", req); end
    cyc();
    redirect = 1'b0; #1;
    checks++; if (state !== ST_FLUSH || valid !== 1'b0) begin errors++; $display("FAIL rw_flush got st=%0d v=%b exp st=2 v=0", state, valid); end
    cyc();
    checks++; if (state !== ST_FLUSH || req !== 1'b0) begin errors++; $display("FAIL rw_flush_hold got st=%0d req=%b exp st=2 req=0", state, req); end
    rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
    cyc();
    rvalid = 1'b0; #1;
    checks++; if (state !== ST_REQ || valid !== 1'b0) begin errors++; $display("FAIL rw_discard got st=%0d v=%b exp st=0 v=0", state, valid); end
    checks++; if (instr !== 32'h4020_81B3) begin errors++; $display("FAIL rw_instr_held got %h exp 402081b3", instr); end
    checks++; if (req !== 1'b1 || addr !== 32'h0000_0100) begin errors++; $display("FAIL rw_target got req=%b addr=%h exp req=1 addr=100", req, addr); end
  endtask

  task automatic test_redirect_clear();
    id_ready = 1'b1; gnt = 1'b1;
    cyc();
    gnt = 1'b0; rvalid = 1'b1; rdata = 32'h0000_0517;
    cyc();
    rvalid = 1'b0; id_ready = 1'b0; #1;
    checks++; if (valid !== 1'b1 || pc !== 32'h100 || opcode !== 7'h17) begin
      errors++; $display("FAIL rc_load got v=%b pc=%h op=%h exp v=1 pc=100 op=17", valid, pc, opcode);
    end
    // redirect while the output holds an unconsumed word
    redirect = 1'b1; redirect_pc = 32'h0000_0202; #1;
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL rc_req_redirect got %b exp 0", req); end
    cyc();
    redirect = 1'b0; #1;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rc_invalidate got %b exp 0", valid); end
    checks++; if (req !== 1'b1 || addr !== 32'h200) begin errors++; $display("FAIL rc_masked got req=%b addr=%h exp req=1 addr=200", req, addr); end
    checks++; if (instr !== 32'h0000_0517 || pc !== 32'h100) begin errors++; $display("FAIL rc_hold got i=%h pc=%h exp i=00000517 pc=100", instr, pc); end
    // redirect coincident with the response
    gnt = 1'b1;
    cyc();
    gnt = 1'b0; rvalid = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0300; rdata = 32'hFFFF_FFFF;
    cyc();
    rvalid = 1'b0; redirect = 1'b0; #1;
    checks++; if (state !== ST_REQ || valid !== 1'b0) begin errors++; $display("FAIL rc_coincide got st=%0d v=%b exp st=0 v=0", state, valid); end
    checks++; if (addr !== 32'h300 || instr !== 32'h0000_0517) begin errors++; $display("FAIL rc_drop got addr=%h i=%h exp addr=300 i=00000517", addr, instr); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] words [3];
    words[0] = 32'h0050_0113;
    words[1] = 32'h0021_81B3;
    words[2] = 32'h0000_006F;
    id_ready = 1'b1; gnt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (req !== 1'b1 || addr !== 32'h300 + 32'(4 * i)) begin
        errors++; $display("FAIL b2b_req[%0d] got req=%b addr=%h exp req=1 addr=%h", i, req, addr, 32'h300 + 32'(4 * i));
      end
      cyc();
      rvalid = 1'b1; rdata = words[i]; #1;
      checks++; if (req !== 1'b0 || state !== ST_WAIT) begin errors++; $display("FAIL b2b_wait[%0d] got req=%b st=%0d exp req=0 st=1", i, req, state); end
      cyc();
      rvalid = 1'b0;
      checks++; if (valid !== 1'b1 || instr !== words[i] || pc !== 32'h300 + 32'(4 * i)) begin
        errors++; $display("FAIL b2b_load[%0d] got v=%b i=%h pc=%h exp v=1 i=%h pc=%h", i, valid, instr, pc, words[i], 32'h300 + 32'(4 * i));
      end
    end
    gnt = 1'b0;
  endtask

  task automatic test_wrap();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    cyc();
    redirect = 1'b0; #1;
    checks++; if (req !== 1'b1 || addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_target got req=%b addr=%h exp req=1 addr=fffffffc", req, addr); end
    gnt = 1'b1;
    cyc();
    gnt = 1'b0; #1;
    checks++; if (addr !== 32'h0) begin errors++; $display("FAIL wrap_pc got %h exp 0", addr); end
    rvalid = 1'b1; rdata = 32'h0000_0073;
    cyc();
    rvalid = 1'b0; #1;
    checks++; if (valid !== 1'b1 || pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_load got v=%b pc=%h exp v=1 pc=fffffffc", valid, pc); end
  endtask

  task automatic test_reset_mid();
    id_ready = 1'b1; gnt = 1'b1;
    cyc();
    gnt = 1'b0; #1;
    checks++; if (state !== ST_WAIT) begin errors++; $display("FAIL rm_wait got %0d exp %0d", state, ST_WAIT); end
    rst = 1'b1;
    cyc();
    rst = 1'b0; #1;
    checks++; if (state !== ST_REQ || valid !== 1'b0 || instr !== NOP || pc !== 32'h0) begin
      errors++; $display("FAIL rm_reset got st=%0d v=%b i=%h pc=%h exp st=0 v=0 i=00000013 pc=0", state, valid, instr, pc);
    end
    rvalid = 1'b1; rdata = 32'hDEAD_BEEF; id_ready = 1'b0; #1;
    checks++; if (req !== 1'b1 || addr !== 32'h0) begin errors++; $display("FAIL rm_boot_req got req=%b addr=%h exp req=1 addr=0", req, addr); end
    cyc();
    rvalid = 1'b0; #1;
    checks++; if (valid !== 1'b0 || state !== ST_REQ || instr !== NOP) begin
      errors++; $display("FAIL rm_stale got v=%b st=%0d i=%h exp v=0 st=0 i=00000013", valid, state, instr);
    end
  endtask

  initial begin
    rst = 1'b1; gnt = 1'b0; rvalid = 1'b0; rdata = 32'h0;
    redirect = 1'b0; redirect_pc = 32'h0; id_ready = 1'b0;
    test_reset();
    test_first_fetch();
    test_stall();
    test_gnt_delay();
    test_redirect_wait();
    test_redirect_clear();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/triumph_if_stage.md
Name: triumph_if_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register; sits directly upstream of the ID controller.
- Generates the PC and fetches 32-bit instructions over a req/gnt/rvalid memory port, at most one transaction outstanding.
- Holds the fetched word in an output register with a valid/ready handshake toward ID, and presents the opcode/funct3/funct7 fields that the ID controller decodes.
- Handles redirects (jump/branch-taken) by retargeting or discarding in-flight fetches.

Parameters:
- BOOT_ADDR, 32'h0000_0000, first fetch address after reset (bits [1:0] must be 0).

Ports:
- clk_i  in  1  clock, all state updates on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- instr_req_o  out  1  fetch request; held until granted.
- instr_addr_o  out  32  fetch address, word aligned.
- instr_gnt_i  in  1  memory accepts request this cycle.
- instr_rvalid_i  in  1  read data valid; arrives 1 or more cycles after gnt.
- instr_rdata_i  in  32  fetched instruction.
- redirect_i  in  1  PC redirect from EX (JAL/JALR/branch taken).
- redirect_pc_i  in  32  redirect target; bits [1:0] ignored and forced to 0.
- id_ready_i  in  1  ID consumes the output register this cycle.
- instr_valid_o  out  1  output register holds a valid instruction.
- instr_o  out  32  instruction word.
- pc_o  out  32  address of instr_o.
- opcode_o  out  7  instr_o[6:0].
- funct3_o  out  3  instr_o[14:12].
- funct7_o  out  7  instr_o[31:25].

Behaviour:
- Reset (rst_i high at an edge):
  - state=S_REQ, pc_q=BOOT_ADDR.
  - instr_valid_o=0, instr_o=32'h0000_0013 (NOP), pc_o=0.
  - Reset mid-transaction abandons it. A stale rvalid arriving after reset is ignored, because the state is S_REQ.
- States:
  - S_REQ: req may be asserted; no transaction outstanding.
  - S_WAIT: granted, awaiting rvalid.
  - S_FLUSH: granted, awaiting rvalid that must be discarded.
- S_REQ:
  - instr_req_o = !redirect_i && (!instr_valid_o || id_ready_i). Only one slot exists, so the response is guaranteed room.
  - instr_addr_o = pc_q.
  - On req && gnt: fetch_pc_q <= pc_q, pc_q <= pc_q+4 (wraps modulo 2^32), go to S_WAIT.
  - Once asserted and not yet granted, req stays high unless redirect_i. On redirect, req drops for that cycle and pc_q <= redirect_pc_i.
- S_WAIT:
  - instr_req_o=0.
  - On rvalid && !redirect_i: instr_o <= rdata, pc_o <= fetch_pc_q, instr_valid_o <= 1, go to S_REQ.
  - On redirect_i without rvalid: go to S_FLUSH.
  - On redirect_i with rvalid: discard data, go to S_REQ.
  - In both redirect cases, pc_q <= redirect_pc_i.
- S_FLUSH:
  - instr_req_o=0.
  - On rvalid: discard, go to S_REQ.
  - A further redirect_i updates pc_q again; the last redirect wins.
- Output register:
  - instr_valid_o clears on id_ready_i && instr_valid_o (unless reloaded the same cycle), and on any redirect_i.
  - Redirect has priority over load and consume.
  - instr_o and pc_o are held when not loading.
  - opcode/funct fields are combinational slices of instr_o.
- Latency:
  - Minimum 2 cycles from req to instr_valid_o with gnt same cycle and rvalid next cycle.
  - Throughput 1 instruction per 2 cycles.
  - First instruction is valid no earlier than cycle 2 after reset release.
- Misaligned redirect: low bits are masked, with no exception.

Decomposition:
- triumph_riscv_defines.v gains:
  - `IF_NOP (32'h0000_0013)
  - `IF_S_REQ/`IF_S_WAIT/`IF_S_FLUSH (2-bit encodings)
  - `BOOT_ADDR_DEFAULT
- No sub-module: FSM, PC register and output register fit in one file.
- The ID controller instance connects to opcode_o/funct3_o/funct7_o directly.

Test Plan:
- Reset release with gnt tied 1 and rvalid one cycle later, memory returning 32'h0010_0093 at 0x0 → instr_valid_o=1 in cycle 2, pc_o=0, opcode_o=7'h13, funct3_o=0. Next req addr is 0x4.
- id_ready_i=0 for 5 cycles with instr_valid_o=1 → instr_req_o stays 0, instr_o/pc_o stable. Raising id_ready_i produces req at the next fetch address in the same cycle.
- gnt delayed 3 cycles → req and addr held constant for 3 cycles; fetch_pc matches the addr at the gnt cycle.
- redirect_i=1, redirect_pc_i=0x0000_0103 while in S_WAIT, rvalid 2 cycles later with 32'hDEAD_BEEF → data discarded, instr_valid_o=0, next req addr=0x0000_0100.
- redirect_i coincident with rvalid and id_ready_i=0 with the output valid → output invalidated, response dropped, next fetch at the redirect target.
- rst_i asserted while in S_WAIT, then rvalid arrives the cycle after reset → ignored. Req is at BOOT_ADDR and instr_o=32'h0000_0013 with valid 0.
